// File: rtl/smg_display_ctrl_pkg.sv
// Shared constants and types for the six-digit seven-segment display controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} for a common-anode display.
package smg_display_ctrl_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [5:0] SCAN_D0  = 6'b011_111;
    localparam logic [5:0] SCAN_OFF = 6'b111_111;

    localparam logic [15:0] T1MS_DEFAULT     = 16'd49999;
    localparam logic [9:0]  BLINK_MS_DEFAULT = 10'd500;
    localparam logic [2:0]  LAST_DIGIT       = 3'd5;

    // One latched display frame; index [23:20] / bit 5 belong to the leftmost digit.
    typedef struct packed {
        logic [23:0] hex;
        logic [5:0]  dp;
        logic [5:0]  blink;
    } frame_t;

endpackage

// File: rtl/smg_encode_module.sv
// Combinational hex-nibble to active-low seven-segment code, with optional decimal point.
module smg_encode_module
    import smg_display_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] code;

    always_comb begin
        code = SEG_BLANK;
        unique case (hex)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            4'hF: code = SEG_F;
        endcase
    end

    // Decimal point is active-low on bit 7.
    assign seg = dp ? (code & 8'h7F) : code;

endmodule

// File: rtl/smg_display_ctrl.sv
// Two-requester arbiter and 1 ms-per-digit scanner for a six-digit common-anode display.
// Frames are swapped only at frame boundaries so a scan never mixes two requesters' data.
module smg_display_ctrl
    import smg_display_ctrl_pkg::*;
#(
    parameter logic [15:0] T1MS     = T1MS_DEFAULT,
    parameter logic [9:0]  BLINK_MS = BLINK_MS_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  Req,
    input  logic [23:0] Hex_Data0,
    input  logic [23:0] Hex_Data1,
    input  logic [5:0]  Dp_Mask0,
    input  logic [5:0]  Dp_Mask1,
    input  logic [5:0]  Blink_Mask0,
    input  logic [5:0]  Blink_Mask1,
    output logic [1:0]  Gnt,
    output logic        Owner,
    output logic        Valid,
    output logic [5:0]  Scan_Sig,
    output logic [7:0]  Smg_Data
);

    logic [15:0] c1_q;
    logic [2:0]  idx_q;
    logic [9:0]  blink_cnt_q;
    logic        blink_ph_q;
    frame_t      frame_q;
    logic        owner_q;
    logic        valid_q;
    logic        last_q;
    logic [5:0]  scan_q;
    logic [7:0]  smg_q;

    logic        tick;
    logic        frame_end;
    logic [1:0]  gnt;
    logic [3:0]  cur_nib;
    logic        cur_dp;
    logic        cur_blink;
    logic [7:0]  seg_code;
    logic [5:0]  scan_d;
    logic [7:0]  smg_d;

    assign tick      = (c1_q == T1MS);
    assign frame_end = tick && (idx_q == LAST_DIGIT);

    // Round robin: on contention the requester that was not granted last wins.
    always_comb begin
        gnt = 2'b00;
        if (frame_end) begin
            unique case (Req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            c1_q  <= '0;
            idx_q <= '0;
        end else begin
            c1_q <= tick ? 16'd0 : c1_q + 16'd1;
            if (tick) begin
                idx_q <= (idx_q == LAST_DIGIT) ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_MS - 10'd1) begin
                blink_cnt_q <= '0;
                blink_ph_q  <= ~blink_ph_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_q <= '0;
            owner_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b1;
        end else if (gnt[0]) begin
            frame_q <= '{hex: Hex_Data0, dp: Dp_Mask0, blink: Blink_Mask0};
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
        end else if (gnt[1]) begin
            frame_q <= '{hex: Hex_Data1, dp: Dp_Mask1, blink: Blink_Mask1};
            owner_q <= 1'b1;
            last_q  <= 1'b1;
            valid_q <= 1'b1;
        end
    end

    // Digit 0 is the leftmost: top nibble and mask bit 5.
    always_comb begin
        cur_nib   = frame_q.hex[23:20];
        cur_dp    = frame_q.dp[5];
        cur_blink = frame_q.blink[5];
        unique case (idx_q)
            3'd1: begin
                cur_nib   = frame_q.hex[19:16];
                cur_dp    = frame_q.dp[4];
                cur_blink = frame_q.blink[4];
            end
            3'd2: begin
                cur_nib   = frame_q.hex[15:12];
                cur_dp    = frame_q.dp[3];
                cur_blink = frame_q.blink[3];
            end
            3'd3: begin
                cur_nib   = frame_q.hex[11:8];
                cur_dp    = frame_q.dp[2];
                cur_blink = frame_q.blink[2];
            end
            3'd4: begin
                cur_nib   = frame_q.hex[7:4];
                cur_dp    = frame_q.dp[1];
                cur_blink = frame_q.blink[1];
            end
            3'd5: begin
                cur_nib   = frame_q.hex[3:0];
                cur_dp    = frame_q.dp[0];
                cur_blink = frame_q.blink[0];
            end
            default: begin
                cur_nib   = frame_q.hex[23:20];
                cur_dp    = frame_q.dp[5];
                cur_blink = frame_q.blink[5];
            end
        endcase
    end

    smg_encode_module u_encode (
        .hex (cur_nib),
        .dp  (cur_dp),
        .seg (seg_code)
    );

    always_comb begin
        scan_d = ~(~SCAN_D0 >> idx_q);
        smg_d  = seg_code;
        if (!valid_q || (blink_ph_q && cur_blink)) begin
            smg_d = SEG_BLANK;
        end
    end

    // Select and segments are registered together so they always refer to the same digit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scan_q <= SCAN_OFF;
            smg_q  <= SEG_BLANK;
        end else begin
            scan_q <= scan_d;
            smg_q  <= smg_d;
        end
    end

    assign Gnt      = gnt;
    assign Owner    = owner_q;
    assign Valid    = valid_q;
    assign Scan_Sig = scan_q;
    assign Smg_Data = smg_q;

endmodule

// File: tb/tb_smg_display_ctrl.sv
// Scoreboard bench for smg_display_ctrl with 10-cycle digit slots and a 2 ms blink half-period.
module tb_smg_display_ctrl;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  Req;
    logic [23:0] Hex_Data0, Hex_Data1;
    logic [5:0]  Dp_Mask0, Dp_Mask1, Blink_Mask0, Blink_Mask1;
    logic [1:0]  Gnt;
    logic        Owner, Valid;
    logic [5:0]  Scan_Sig;
    logic [7:0]  Smg_Data;

    typedef struct packed {
        logic [5:0] scan;
        logic [7:0] smg;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frame_no;
    logic [23:0] disp_hex;
    logic [5:0]  disp_dp, disp_blink;
    logic        disp_valid;
    logic        owner_m;
    logic [5:0]  scan_tab [6] = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};

    smg_display_ctrl #(
        .T1MS     (16'd9),
        .BLINK_MS (10'd2)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Req         (Req),
        .Hex_Data0   (Hex_Data0),
        .Hex_Data1   (Hex_Data1),
        .Dp_Mask0    (Dp_Mask0),
        .Dp_Mask1    (Dp_Mask1),
        .Blink_Mask0 (Blink_Mask0),
        .Blink_Mask1 (Blink_Mask1),
        .Gnt         (Gnt),
        .Owner       (Owner),
        .Valid       (Valid),
        .Scan_Sig    (Scan_Sig),
        .Smg_Data    (Smg_Data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Phase toggles every 20 cycles; sample of digit d in frame f is registered at 60f+5+10d.
    function automatic logic phase_of(input int f, input int d);
        return ((3 * f + d / 2) % 2) == 1;
    endfunction

    task automatic push_frame();
        exp_t e;
        logic [3:0] nib;
        for (int d = 0; d < 6; d++) begin
            e.scan = scan_tab[d];
            nib    = disp_hex[(23 - 4 * d) -: 4];
            if (!disp_valid || (disp_blink[5 - d] && phase_of(frame_no, d))) begin
                e.smg = 8'hFF;
            end else begin
                e.smg = seg_of(nib);
                if (disp_dp[5 - d]) e.smg[7] = 1'b0;
            end
            sb_q.push_back(e);
        end
    endtask

    // Entered at the negedge of a frame_end cycle; leaves at the negedge after the next posedge.
    task automatic frame_boundary(input logic [1:0] gnt_exp, input logic [1:0] req_next);
        #1;
        check_val("gnt_pulse", Gnt, gnt_exp);
        if (gnt_exp[0]) begin
            disp_hex = Hex_Data0; disp_dp = Dp_Mask0; disp_blink = Blink_Mask0;
            owner_m = 1'b0; disp_valid = 1'b1;
        end else if (gnt_exp[1]) begin
            disp_hex = Hex_Data1; disp_dp = Dp_Mask1; disp_blink = Blink_Mask1;
            owner_m = 1'b1; disp_valid = 1'b1;
        end
        @(posedge CLK);
        @(negedge CLK);
        check_val("gnt_after", Gnt, 2'b00);
        check_val("owner", Owner, owner_m);
        check_val("valid", Valid, disp_valid);
        Req = req_next;
        frame_no++;
        push_frame();
    endtask

    // Samples mid-slot for each digit; optional stimulus change while digit 2 is scanned.
    task automatic scan_frame(input logic mid_en, input logic [1:0] mid_req,
                              input logic [23:0] mid_hex0);
        exp_t e;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 6; d++) begin
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_val($sformatf("scan_f%0d_d%0d", frame_no, d), Scan_Sig, e.scan);
                check_val($sformatf("smg_f%0d_d%0d", frame_no, d), Smg_Data, e.smg);
            end
            if (d == 2 && mid_en) begin
                Req = mid_req;
                Hex_Data0 = mid_hex0;
            end
            if (d < 5) begin
                repeat (10) @(posedge CLK);
                @(negedge CLK);
            end
        end
        repeat (4) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        frame_no = 0;
        disp_valid = 1'b0;
        owner_m = 1'b0;
        push_frame();
    endtask

    initial begin
        RST_N = 1'b0;
        Req = 2'b00;
        Hex_Data0 = '0; Hex_Data1 = '0;
        Dp_Mask0 = '0; Dp_Mask1 = '0; Blink_Mask0 = '0; Blink_Mask1 = '0;
        disp_hex = '0; disp_dp = '0; disp_blink = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_scan", Scan_Sig, 6'h3F);
        check_val("rst_smg", Smg_Data, 8'hFF);
        check_val("rst_gnt", Gnt, 2'b00);
        check_val("rst_owner", Owner, 1'b0);
        check_val("rst_valid", Valid, 1'b0);
        release_reset();
        check_val("rel_scan", Scan_Sig, 6'h3F);
        scan_frame(1'b0, 2'b00, 24'h0);

        // Single request
        Hex_Data0 = 24'h123456;
        Req = 2'b01;
        frame_boundary(2'b01, 2'b00);
        scan_frame(1'b1, 2'b10, 24'h123456);
        Req = 2'b00;  // withdrawn before frame_end
        frame_boundary(2'b00, 2'b00);
        scan_frame(1'b0, 2'b00, 24'h0);

        // Contention
        Hex_Data1 = 24'hABCDEF;
        Dp_Mask1 = 6'b101010;
        Req = 2'b11;
        frame_boundary(2'b10, 2'b11);
        scan_frame(1'b0, 2'b00, 24'h0);
        frame_boundary(2'b01, 2'b11);
        scan_frame(1'b0, 2'b00, 24'h0);
        frame_boundary(2'b10, 2'b00);

        // Mid-frame request and data change must not tear the current frame
        scan_frame(1'b1, 2'b01, 24'h654321);
        frame_boundary(2'b01, 2'b00);
        scan_frame(1'b1, 2'b00, 24'h0FEDCB);

        // Blink and decimal point
        Hex_Data0 = 24'h000000;
        Dp_Mask0 = 6'b000001;
        Blink_Mask0 = 6'b100000;
        Req = 2'b01;
        frame_boundary(2'b01, 2'b00);
        scan_frame(1'b0, 2'b00, 24'h0);
        frame_boundary(2'b00, 2'b00);
        scan_frame(1'b0, 2'b00, 24'h0);
        frame_boundary(2'b00, 2'b00);
        scan_frame(1'b0, 2'b00, 24'h0);

        // Asynchronous reset while digit 3 is scanned
        frame_boundary(2'b00, 2'b00);
        sb_q.delete();
        repeat (35) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check_val("arst_scan", Scan_Sig, 6'h3F);
        check_val("arst_smg", Smg_Data, 8'hFF);
        check_val("arst_valid", Valid, 1'b0);
        check_val("arst_owner", Owner, 1'b0);
        repeat (2) @(posedge CLK);
        Hex_Data0 = 24'hABCDEF;
        Dp_Mask0 = 6'b000000;
        Blink_Mask0 = 6'b000000;
        release_reset();
        Req = 2'b01;
        scan_frame(1'b0, 2'b00, 24'h0);
        frame_boundary(2'b01, 2'b00);
        scan_frame(1'b0, 2'b00, 24'h0);

        check_val("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
